// File: rtl/lfsr_share_arb.sv
// Round-robin arbiter that hands out words from one shared external LFSR,
// advancing it only on a completed handshake and deferring reseeds to idle.
module lfsr_share_arb #(
    parameter int NREQ = 4,
    parameter int PTRW = $clog2(NREQ)
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] rnd_valid,
    input  logic [NREQ-1:0] rnd_ready,
    output logic [31:0]     rnd_data,
    input  logic            reseed,
    output logic            lfsr_en,
    output logic            lfsr_srst,
    input  logic [31:0]     lfsr_value,
    output logic            busy,
    output logic [31:0]     draw_cnt
);

    typedef enum logic [1:0] {IDLE, SERVE, RESEED} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PTRW-1:0] grant;
    logic [PTRW-1:0] grant_nxt;
    logic [PTRW-1:0] last_grant;
    logic [PTRW-1:0] pick;
    logic [PTRW-1:0] cand;
    logic            found;
    logic            handshake;
    logic            reseed_pending;
    logic            pending_nxt;

    // Rotating priority: first requester strictly after the last one served.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PTRW'((int'(last_grant) + i) % NREQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign handshake   = (state == SERVE) && rnd_ready[grant];
    assign pending_nxt = reseed || (reseed_pending && (state != IDLE));

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (reseed_pending) begin
                    state_nxt = RESEED;
                end else if (found) begin
                    state_nxt = SERVE;
                    grant_nxt = pick;
                end
            end
            SERVE: begin
                if (handshake) state_nxt = IDLE;
            end
            RESEED:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rnd_valid = '0;
        if (state == SERVE) rnd_valid[grant] = 1'b1;
    end

    // The LFSR only moves on handshake, so the pass-through is stable in SERVE.
    assign rnd_data  = lfsr_value;
    assign lfsr_en   = handshake;
    assign lfsr_srst = (state == RESEED);
    assign busy      = (state != IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= IDLE;
            grant          <= '0;
            last_grant     <= PTRW'(NREQ - 1);
            draw_cnt       <= '0;
            reseed_pending <= 1'b0;
        end else begin
            state          <= state_nxt;
            grant          <= grant_nxt;
            reseed_pending <= pending_nxt;
            if (handshake) begin
                draw_cnt   <= draw_cnt + 32'd1;
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_share_arb.sv
// Bench for lfsr_share_arb: external LFSR, transaction-level reference model,
// per-cycle output comparison and directed scenarios with hand-derived words.
module tb_lfsr_share_arb;

    localparam int          NREQ = 4;
    localparam logic [31:0] KEY  = 32'hFFFF_FFFF;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  req;
    logic [3:0]  rnd_valid;
    logic [3:0]  rnd_ready;
    logic [31:0] rnd_data;
    logic        reseed;
    logic        lfsr_en;
    logic        lfsr_srst;
    logic [31:0] lfsr_value;
    logic        busy;
    logic [31:0] draw_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int en_seen = 0;
    int srst_seen = 0;
    int vld_seen = 0;

    // Reference model: who is being served (-1 = nobody), reseed in progress,
    // pending reseed, last served requester, delivered count, expected LFSR word.
    int          m_serving = -1;
    bit          m_reseeding = 1'b0;
    bit          m_pend = 1'b0;
    int          m_last = NREQ - 1;
    logic [31:0] m_cnt = '0;
    logic [31:0] m_lfsr = KEY;
    int          m_idx;
    bit          m_hs;
    bit          m_pend_now;
    int          log_grant[$];
    logic [31:0] log_word[$];

    logic [31:0] lfsr_q;
    logic [31:0] wseq [10] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFB,
                               32'hFFFFFFF6, 32'hFFFFFFED, 32'hFFFFFFDB, 32'hFFFFFFB6,
                               32'hFFFFFF6D, 32'hFFFFFEDB};

    lfsr_share_arb #(.NREQ(NREQ)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req        (req),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .reseed     (reseed),
        .lfsr_en    (lfsr_en),
        .lfsr_srst  (lfsr_srst),
        .lfsr_value (lfsr_value),
        .busy       (busy),
        .draw_cnt   (draw_cnt)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    // The shared external LFSR the arbiter drives.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)       lfsr_q <= KEY;
        else if (lfsr_srst) lfsr_q <= KEY;
        else if (lfsr_en)   lfsr_q <= lfsr_step(lfsr_q);
    end
    assign lfsr_value = lfsr_q;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic chk_draw(input string name, input int idx, input int g, input logic [31:0] w);
        if (idx >= log_word.size()) begin
            chk({name, "_missing"}, 32'(log_word.size()), 32'(idx + 1));
        end else begin
            chk({name, "_grant"}, 32'(log_grant[idx]), 32'(g));
            chk({name, "_word"}, log_word[idx], w);
        end
    endtask

    initial begin : model
        forever begin
            @(posedge aclk or negedge aresetn);
            if (!aresetn) begin
                m_serving   = -1;
                m_reseeding = 1'b0;
                m_pend      = 1'b0;
                m_last      = NREQ - 1;
                m_cnt       = '0;
                m_lfsr      = KEY;
            end else begin
                m_pend_now = m_pend;
                m_hs = (m_serving >= 0) && rnd_ready[m_serving[1:0]];
                if (m_reseeding) begin
                    m_lfsr      = KEY;
                    m_reseeding = 1'b0;
                end else if (m_serving >= 0) begin
                    if (m_hs) begin
                        log_grant.push_back(m_serving);
                        log_word.push_back(m_lfsr);
                        m_lfsr    = lfsr_step(m_lfsr);
                        m_cnt     = m_cnt + 32'd1;
                        m_last    = m_serving;
                        m_serving = -1;
                    end
                end else if (m_pend_now) begin
                    m_reseeding = 1'b1;
                    m_pend_now  = 1'b0;
                end else begin
                    for (int k = 1; k <= NREQ; k++) begin
                        m_idx = (m_last + k) % NREQ;
                        if (m_serving < 0 && req[m_idx[1:0]]) m_serving = m_idx;
                    end
                end
                if (reseed) m_pend_now = 1'b1;
                m_pend = m_pend_now;
            end
        end
    end

    initial begin : compare
        logic [3:0] ev;
        logic       een;
        logic       ebusy;
        forever begin
            @(negedge aclk);
            ev    = (m_serving >= 0) ? (4'b0001 << m_serving[1:0]) : 4'b0000;
            een   = (m_serving >= 0) && rnd_ready[m_serving[1:0]];
            ebusy = (m_serving >= 0) || m_reseeding;
            chk("valid", 32'(rnd_valid), 32'(ev));
            chk("data", rnd_data, m_lfsr);
            chk("lfsr_en", 32'(lfsr_en), 32'(een));
            chk("lfsr_srst", 32'(lfsr_srst), 32'(m_reseeding));
            chk("busy", 32'(busy), 32'(ebusy));
            chk("draw_cnt", draw_cnt, m_cnt);
            chk("en_srst_excl", 32'(lfsr_en & lfsr_srst), 32'h0);
            en_seen   += int'(lfsr_en);
            srst_seen += int'(lfsr_srst);
            vld_seen  += int'(rnd_valid != 4'b0000);
        end
    end

    initial begin : stim
        int base;
        int e0;
        int s0;
        int v0;
        aresetn   = 1'b0;
        req       = 4'b0000;
        rnd_ready = 4'b0000;
        reseed    = 1'b0;
        tick(3);
        chk("rst_valid", 32'(rnd_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnt", draw_cnt, 32'h0);
        chk("rst_strobes", 32'({lfsr_en, lfsr_srst}), 32'h0);
        aresetn = 1'b1;
        tick(2);

        // single requester, four back-to-back draws
        base = log_word.size(); e0 = en_seen; v0 = vld_seen;
        req = 4'b0001; rnd_ready = 4'b1111;
        tick(1);
        chk("t1_first_valid", 32'(rnd_valid), 32'h1);
        chk("t1_first_data", rnd_data, 32'hFFFFFFFF);
        tick(6);
        req = 4'b0000;
        tick(3);
        for (int i = 0; i < 4; i++) chk_draw("t1", base + i, 0, wseq[i]);
        chk("t1_cnt", draw_cnt, 32'd4);
        chk("t1_en_pulses", 32'(en_seen - e0), 32'd4);
        chk("t1_valid_cycles", 32'(vld_seen - v0), 32'd4);

        aresetn = 1'b0;
        tick(2);
        aresetn = 1'b1;
        tick(1);

        // round robin over all four, then a sparse request mask
        base = log_word.size();
        req = 4'b1111;
        tick(11);
        req = 4'b1010;
        tick(4);
        req = 4'b0000;
        tick(3);
        begin
            int order[8] = '{0, 1, 2, 3, 0, 1, 3, 1};
            for (int i = 0; i < 8; i++) chk_draw("t2", base + i, order[i], wseq[i]);
        end
        chk("t2_cnt", draw_cnt, 32'd8);

        // backpressure on requester 2, request withdrawn while waiting
        base = log_word.size(); e0 = en_seen;
        req = 4'b0100; rnd_ready = 4'b1011;
        tick(1);
        chk("t3_valid_a", 32'(rnd_valid), 32'h4);
        chk("t3_data_a", rnd_data, wseq[8]);
        tick(2);
        req = 4'b0000;
        tick(2);
        chk("t3_valid_b", 32'(rnd_valid), 32'h4);
        chk("t3_data_b", rnd_data, wseq[8]);
        chk("t3_en_held", 32'(lfsr_en), 32'h0);
        tick(1);
        rnd_ready = 4'b1111;
        tick(1);
        chk("t3_valid_done", 32'(rnd_valid), 32'h0);
        chk("t3_cnt", draw_cnt, 32'd9);
        chk("t3_en_pulses", 32'(en_seen - e0), 32'd1);
        chk_draw("t3", base, 2, wseq[8]);

        // reseed arriving mid-transaction
        base = log_word.size(); s0 = srst_seen;
        req = 4'b0001; rnd_ready = 4'b0000;
        tick(1);
        reseed = 1'b1;
        chk("t4_data_inflight", rnd_data, wseq[9]);
        tick(1);
        reseed = 1'b0; rnd_ready = 4'b0001; req = 4'b0000;
        tick(2);
        chk("t4_srst", 32'(lfsr_srst), 32'h1);
        chk("t4_en_off", 32'(lfsr_en), 32'h0);
        tick(1);
        req = 4'b0001;
        tick(1);
        chk("t4_key_word", rnd_data, KEY);
        req = 4'b0000;
        tick(2);
        chk_draw("t4a", base, 0, wseq[9]);
        chk_draw("t4b", base + 1, 0, KEY);
        chk("t4_srst_pulses", 32'(srst_seen - s0), 32'd1);
        chk("t4_cnt", draw_cnt, 32'd11);

        // pending reseed beats a waiting request
        reseed = 1'b1;
        tick(1);
        reseed = 1'b0; req = 4'b0001; rnd_ready = 4'b1111;
        chk("t5_pre_data", rnd_data, 32'hFFFFFFFE);
        tick(1);
        chk("t5_srst", 32'(lfsr_srst), 32'h1);
        chk("t5_no_valid", 32'(rnd_valid), 32'h0);
        tick(2);
        chk("t5_valid", 32'(rnd_valid), 32'h1);
        chk("t5_data", rnd_data, KEY);
        req = 4'b0000;
        tick(2);
        chk("t5_cnt", draw_cnt, 32'd12);

        // asynchronous reset in the middle of a transaction
        req = 4'b0100; rnd_ready = 4'b0000;
        tick(1);
        chk("t6_valid_pre", 32'(rnd_valid), 32'h4);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(rnd_valid), 32'h0);
        chk("t6_busy_rst", 32'(busy), 32'h0);
        chk("t6_cnt_rst", draw_cnt, 32'h0);
        chk("t6_strobes_rst", 32'({lfsr_en, lfsr_srst}), 32'h0);
        req = 4'b0110; rnd_ready = 4'b1111;
        @(posedge aclk);
        #3;
        aresetn = 1'b1;
        tick(1);
        chk("t6_first_grant", 32'(rnd_valid), 32'h2);
        chk("t6_cnt_zero", draw_cnt, 32'h0);
        chk("t6_data", rnd_data, KEY);
        req = 4'b0000;
        tick(1);
        chk("t6_cnt_one", draw_cnt, 32'd1);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_share_arb.md
Name: lfsr_share_arb

Overview:
- Controller that shares one external 32-bit LFSR (X^32+X^22+X^2+X^1, driven via en/srst) between NREQ testbench requesters.
- Round-robin arbitration; each granted requester receives exactly one fresh pseudo-random word through a valid/ready handshake.
- Advances the LFSR only on a completed handshake; sequences reseed requests, deferring them to a transaction boundary.
- Sits in the SVUT testbench beside the random-traffic drivers, so several drivers draw from one reproducible random stream.

Parameters:
- NREQ, 4, number of requesters (2..16).
- PTRW, $clog2(NREQ), width of the grant index.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester draw request, level-sensitive.
- rnd_valid  out  NREQ  one-hot; word available to requester i.
- rnd_ready  in  NREQ  per-requester accept.
- rnd_data  out  32  random word, shared by all requesters.
- reseed  in  1  single-cycle pulse; request LFSR return to KEY.
- lfsr_en  out  1  advance strobe to the LFSR.
- lfsr_srst  out  1  synchronous reset strobe to the LFSR.
- lfsr_value  in  32  current LFSR output.
- busy  out  1  high in SERVE or RESEED.
- draw_cnt  out  32  completed handshakes since reset.

Behaviour:
- Reset (aresetn low, async) sets:
  - state=IDLE, rnd_valid=0, lfsr_en=0, lfsr_srst=0, busy=0, draw_cnt=0, reseed_pending=0.
  - last_grant=NREQ-1, so the first grant goes to requester 0.
- rnd_data = lfsr_value, combinational pass-through. It is stable during SERVE because the LFSR only advances on handshake.
- lfsr_en and lfsr_srst are combinational from state and are never both high.
- reseed_pending:
  - Set by reseed in any state.
  - Cleared on the IDLE->RESEED transition.
  - If reseed arrives in that same cycle, set wins and the flag stays 1.
- States:
  - IDLE:
    - If reseed_pending, go to RESEED. Reseed has priority over req.
    - Else if req!=0, grant = first set bit scanning from last_grant+1 upward, wrapping modulo NREQ. Register the grant and go to SERVE.
    - Else stay in IDLE.
  - SERVE:
    - rnd_valid[grant]=1; all other bits 0.
    - On rnd_ready[grant]: lfsr_en=1 for that cycle, draw_cnt+=1 (wraps 2^32-1 -> 0), last_grant=grant, go to IDLE.
    - rnd_ready on non-granted bits is ignored.
    - rnd_valid is held until the handshake even if req[grant] drops. No withdrawal.
  - RESEED: lfsr_srst=1 for exactly one cycle, then go to IDLE.
- Latency and throughput:
  - req asserted in IDLE at cycle N -> rnd_valid at N+1.
  - Minimum 2 cycles per word (IDLE+SERVE).
  - The LFSR shows its new value the cycle after the handshake.
- Reseed during SERVE is deferred until the handshake completes. The in-flight word is the pre-reseed value. The next word after RESEED equals KEY.
- Reset mid-SERVE: valid drops immediately (async); the in-flight word is lost; draw_cnt=0.
- busy = (state!=IDLE).

Test Plan:
1. Single requester: req=4'b0001, ready always 1, 4 draws:
   - rnd_data sequence equals LFSR from KEY 0xFFFFFFFF.
   - lfsr_en pulses 4 times.
   - draw_cnt=4.
   - valid every 2nd cycle.
2. Round-robin: req=4'b1111 held, ready=1:
   - grant order 0,1,2,3,0,1.
   - Each word distinct and consecutive in the LFSR sequence.
   - req=4'b1010 after grant 1 -> next grant 3, then 1.
3. Backpressure: requester 2 holds ready=0 for 5 cycles:
   - rnd_valid=4'b0100 and rnd_data stay constant.
   - lfsr_en stays 0.
   - req[2] dropped mid-wait does not clear valid.
   - Completes on ready.
4. Deferred reseed: pulse reseed during SERVE:
   - Current word delivered, then a one-cycle lfsr_srst.
   - Next delivered word = 0xFFFFFFFF.
   - lfsr_en and lfsr_srst are never high together.
5. Reseed vs req priority: reseed pulse with req=4'b0001 in IDLE -> RESEED occurs before the next SERVE.
6. Async reset: assert aresetn low mid-SERVE:
   - All outputs are at reset values within the same cycle.
   - After release, the first grant goes to the lowest requesting index.
   - draw_cnt restarts at 0.
